// File: rtl/char_out_arbiter.sv
// Console arbiter: per-source byte FIFOs, line-atomic round-robin grant,
// and a strobe/gap output sequencer driving a single character sink.
module char_out_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int FIFO_DEPTH    = 16,
  parameter int STROBE_CYCLES = 2,
  parameter int GAP_CYCLES    = 1,
  parameter int LINE_TIMEOUT  = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_char,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           term_char,
  output logic                 term_strobe,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int PW   = AW + 1;
  localparam int IW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CMAX = (STROBE_CYCLES > GAP_CYCLES) ?
                        STROBE_CYCLES : GAP_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int TW   = $clog2(LINE_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STROBE,
    S_GAP
  } state_e;

  logic [7:0]   mem_q [NUM_REQ][FIFO_DEPTH];
  logic [PW-1:0] wptr_q [NUM_REQ];
  logic [PW-1:0] wptr_d [NUM_REQ];
  logic [PW-1:0] rptr_q [NUM_REQ];
  logic [PW-1:0] rptr_d [NUM_REQ];

  logic [NUM_REQ-1:0] full;
  logic [NUM_REQ-1:0] empty;
  logic [NUM_REQ-1:0] push;
  logic [NUM_REQ-1:0] pop;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    char_q, char_d;
  logic          strobe_q, strobe_d;

  logic          gvld_q, gvld_d;
  logic [IW-1:0] gidx_q, gidx_d;
  logic [IW-1:0] last_q, last_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic [IW-1:0] pick;
  logic [IW-1:0] cand;
  logic          pick_vld;
  logic          idle_empty;
  logic          rel_lf;
  logic          rel_tmo;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      full[i]  = (wptr_q[i][AW] != rptr_q[i][AW]) &&
                 (wptr_q[i][AW-1:0] == rptr_q[i][AW-1:0]);
      empty[i] = (wptr_q[i] == rptr_q[i]);
      push[i]  = req_valid[i] & ~full[i];
    end
  end

  assign req_ready = ~full;

  // Search downwards so the candidate nearest last+1 wins.
  always_comb begin
    pick     = '0;
    cand     = '0;
    pick_vld = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IW'((int'(last_q) + k) % NUM_REQ);
      if (!empty[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    char_d   = char_q;
    strobe_d = strobe_q;
    pop      = '0;
    unique case (state_q)
      S_IDLE: begin
        if (gvld_q && !empty[gidx_q]) begin
          pop[gidx_q] = 1'b1;
          char_d   = mem_q[gidx_q][rptr_q[gidx_q][AW-1:0]];
          state_d  = S_STROBE;
          cnt_d    = CW'(STROBE_CYCLES - 1);
          strobe_d = 1'b1;
        end
      end
      S_STROBE: begin
        if (cnt_q == '0) begin
          state_d  = S_GAP;
          cnt_d    = CW'(GAP_CYCLES - 1);
          strobe_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d  = S_IDLE;
        strobe_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    gvld_d = gvld_q;
    gidx_d = gidx_q;
    last_d = last_q;
    idle_empty = gvld_q && (state_q == S_IDLE) && empty[gidx_q];
    rel_lf  = gvld_q && (state_q == S_GAP) && (cnt_q == '0) &&
              (char_q == 8'h0A);
    rel_tmo = idle_empty && !push[gidx_q] &&
              (tmo_q == TW'(LINE_TIMEOUT - 1));
    tmo_d = (idle_empty && !push[gidx_q]) ? tmo_q + TW'(1) : '0;
    if (rel_lf || rel_tmo) begin
      gvld_d = 1'b0;
      last_d = gidx_q;
      tmo_d  = '0;
    end else if (!gvld_q && pick_vld) begin
      gvld_d = 1'b1;
      gidx_d = pick;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      wptr_d[i] = wptr_q[i] + PW'(push[i]);
      rptr_d[i] = rptr_q[i] + PW'(pop[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      char_q   <= 8'h00;
      strobe_q <= 1'b0;
      gvld_q   <= 1'b0;
      gidx_q   <= '0;
      last_q   <= IW'(NUM_REQ - 1);
      tmo_q    <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      char_q   <= char_d;
      strobe_q <= strobe_d;
      gvld_q   <= gvld_d;
      gidx_q   <= gidx_d;
      last_q   <= last_d;
      tmo_q    <= tmo_d;
      for (int i = 0; i < NUM_REQ; i++) begin
        wptr_q[i] <= wptr_d[i];
        rptr_q[i] <= rptr_d[i];
      end
    end
  end

  // Storage needs no reset: pointers alone define contents.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (push[i]) begin
        mem_q[i][wptr_q[i][AW-1:0]] <= req_char[8*i +: 8];
      end
    end
  end

  always_comb begin
    grant = '0;
    if (gvld_q) begin
      grant[gidx_q] = 1'b1;
    end
  end

  assign term_char   = char_q;
  assign term_strobe = strobe_q;
  assign busy        = (|(~empty)) || (state_q != S_IDLE);

endmodule
